// File: rtl/arm_branch_pkg.sv
// arm_branch_pkg: condition codes, redirect FSM encoding and Thumb branch offset field positions
package arm_branch_pkg;
  localparam logic [3:0] CC_EQ = 4'h0, CC_NE = 4'h1, CC_CS = 4'h2, CC_CC = 4'h3,
                         CC_MI = 4'h4, CC_PL = 4'h5, CC_VS = 4'h6, CC_VC = 4'h7,
                         CC_HI = 4'h8, CC_LS = 4'h9, CC_GE = 4'hA, CC_LT = 4'hB,
                         CC_GT = 4'hC, CC_LE = 4'hD, CC_AL = 4'hE, CC_NV = 4'hF;
  localparam int COND_LSB = 8;
  localparam int COND_MSB = 11;
  localparam int T1_IMM_MSB = 7;
  localparam int T2_IMM_MSB = 10;
  typedef enum logic [1:0] {ST_IDLE, ST_REDIRECT, ST_FLUSH} state_t;
endpackage

// File: rtl/branch_target_adder.sv
// branch_target_adder: pc + 4 + sign-extended halfword offset for Thumb B<cond> T1 / B T2, bit0 cleared
module branch_target_adder
  import arm_branch_pkg::*;
(
  input  logic [31:0] pc,
  input  logic [10:0] imm,
  input  logic        is_b,
  output logic [31:0] target
);
  logic [31:0] off;
  always_comb begin
    off = is_b ? {{20{imm[T2_IMM_MSB]}}, imm[T2_IMM_MSB:0], 1'b0}
               : {{23{imm[T1_IMM_MSB]}}, imm[T1_IMM_MSB:0], 1'b0};
    target = (pc + 32'd4 + off) & 32'hFFFF_FFFE;
  end
endmodule

// File: rtl/branch_redirect.sv
// branch_redirect: EX-stage branch resolve, fetch redirect handshake and younger-stage flush (BRANCH_STATS_EN adds stat_taken/stat_nottaken)
module branch_redirect
  import arm_branch_pkg::*;
#(
  parameter int FLUSH_CYCLES = 2
`ifdef BRANCH_STATS_EN
  ,parameter int CNT_W = 16
`endif
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ex_valid,
  output logic        ex_ready,
  input  logic [31:0] ex_instr,
  input  logic [31:0] ex_pc,
  input  logic        ex_is_bcond,
  input  logic        ex_is_b,
  input  logic        cond_taken,
  output logic        redirect_valid,
  input  logic        redirect_ready,
  output logic [31:0] redirect_pc,
  output logic        flush,
  output logic        undef_branch
`ifdef BRANCH_STATS_EN
  ,output logic [CNT_W-1:0] stat_taken
  ,output logic [CNT_W-1:0] stat_nottaken
`endif
);
  localparam int CW = FLUSH_CYCLES > 1 ? $clog2(FLUSH_CYCLES + 1) : 1;
  state_t state, state_nx;
  logic [CW-1:0] cnt;
  logic [3:0] cond;
  logic accept, take, undef_cond;
  logic [31:0] target;
  logic unused_instr;
  assign unused_instr = ^{ex_instr[31:16], ex_instr[15:12]};
  assign cond = ex_instr[COND_MSB:COND_LSB];
  assign accept = ex_valid & ex_ready;
  assign take = ex_is_b | (ex_is_bcond & cond_taken & (cond < CC_AL));
  assign undef_cond = accept & ex_is_bcond & !ex_is_b & (cond >= CC_AL);
  branch_target_adder u_adder (
    .pc    (ex_pc),
    .imm   (ex_instr[10:0]),
    .is_b  (ex_is_b),
    .target(target)
  );
  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else state <= state_nx;
  end
  always_comb begin
    state_nx = state == ST_IDLE     ? (accept & take ? ST_REDIRECT : ST_IDLE)
             : state == ST_REDIRECT ? (redirect_ready ? (FLUSH_CYCLES == 0 ? ST_IDLE : ST_FLUSH) : ST_REDIRECT)
             : (cnt == CW'(1) ? ST_IDLE : ST_FLUSH);
  end
  always_comb begin
    ex_ready = state == ST_IDLE;
    redirect_valid = state == ST_REDIRECT;
    flush = state != ST_IDLE;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
      redirect_pc <= '0;
      undef_branch <= 1'b0;
    end else begin
      undef_branch <= undef_cond;
      if (accept & take) redirect_pc <= target;
      cnt <= state == ST_REDIRECT ? CW'(FLUSH_CYCLES) : state == ST_FLUSH ? cnt - CW'(1) : cnt;
    end
  end
`ifdef BRANCH_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      stat_taken <= '0;
      stat_nottaken <= '0;
    end else begin
      if (accept & take & ~&stat_taken) stat_taken <= stat_taken + 1'b1;
      if (accept & ex_is_bcond & !take & (cond < CC_AL) & ~&stat_nottaken) stat_nottaken <= stat_nottaken + 1'b1;
    end
  end
`endif
endmodule

// File: tb/tb_branch_redirect.sv
// tb_branch_redirect: directed self-checking bench for branch_redirect with FLUSH_CYCLES=2
module tb_branch_redirect;
  logic clk = 1'b0;
  logic rst, ex_valid, ex_ready, ex_is_bcond, ex_is_b, cond_taken;
  logic redirect_valid, redirect_ready, flush, undef_branch;
  logic [31:0] ex_instr, ex_pc, redirect_pc;
  logic [3:0] st;
  int passed = 0;
  int total = 0;
  always #5 clk = ~clk;
  assign st = {ex_ready, redirect_valid, flush, undef_branch};
  branch_redirect #(.FLUSH_CYCLES(2)) dut (
    .clk(clk), .rst(rst), .ex_valid(ex_valid), .ex_ready(ex_ready),
    .ex_instr(ex_instr), .ex_pc(ex_pc), .ex_is_bcond(ex_is_bcond), .ex_is_b(ex_is_b),
    .cond_taken(cond_taken), .redirect_valid(redirect_valid), .redirect_ready(redirect_ready),
    .redirect_pc(redirect_pc), .flush(flush), .undef_branch(undef_branch)
  );
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic clear_ex;
    ex_valid = 0; ex_is_b = 0; ex_is_bcond = 0; cond_taken = 0; ex_instr = 0; ex_pc = 0;
  endtask
  task automatic issue(input logic [31:0] pc, input logic [31:0] instr, input logic b, input logic bc, input logic tk);
    ex_valid = 1; ex_pc = pc; ex_instr = instr; ex_is_b = b; ex_is_bcond = bc; cond_taken = tk;
    tick;
    clear_ex;
  endtask
  task automatic test_reset;
    rst = 1; redirect_ready = 0; clear_ex;
    tick; tick;
    rst = 0;
    total++; if (st !== 4'b1000) $display("FAIL reset_status got %b want 1000", st); else passed++;
    total++; if (redirect_pc !== 32'h0) $display("FAIL reset_pc got %h want 00000000", redirect_pc); else passed++;
  endtask
  task automatic test_beq_taken;
    redirect_ready = 1;
    issue(32'h100, 32'hD005, 0, 1, 1);
    total++; if (st !== 4'b0110) $display("FAIL beq_redirect got %b want 0110", st); else passed++;
    total++; if (redirect_pc !== 32'h10E) $display("FAIL beq_pc got %h want 0000010e", redirect_pc); else passed++;
    tick;
    total++; if (st !== 4'b0010) $display("FAIL beq_flush1 got %b want 0010", st); else passed++;
    tick;
    total++; if (st !== 4'b0010) $display("FAIL beq_flush2 got %b want 0010", st); else passed++;
    tick;
    total++; if (st !== 4'b1000) $display("FAIL beq_idle got %b want 1000", st); else passed++;
  endtask
  task automatic test_backward;
    issue(32'h200, 32'hD1FE, 0, 1, 1);
    total++; if (redirect_pc !== 32'h200) $display("FAIL back_pc got %h want 00000200", redirect_pc); else passed++;
    repeat (3) tick;
    total++; if (st !== 4'b1000) $display("FAIL back_idle got %b want 1000", st); else passed++;
  endtask
  task automatic test_not_taken;
    issue(32'h500, 32'hD005, 0, 1, 0);
    total++; if (st !== 4'b1000) $display("FAIL nt_status got %b want 1000", st); else passed++;
    total++; if (redirect_pc !== 32'h200) $display("FAIL nt_pc got %h want 00000200", redirect_pc); else passed++;
    issue(32'h600, 32'h1234, 0, 0, 1);
    total++; if (st !== 4'b1000) $display("FAIL nonbranch_status got %b want 1000", st); else passed++;
  endtask
  task automatic test_t2;
    issue(32'hFFFF_FFFC, 32'hE000, 1, 0, 0);
    total++; if (redirect_pc !== 32'h0) $display("FAIL t2_wrap_pc got %h want 00000000", redirect_pc); else passed++;
    total++; if (st !== 4'b0110) $display("FAIL t2_wrap_status got %b want 0110", st); else passed++;
    repeat (3) tick;
    issue(32'h1000, 32'hE7FF, 1, 0, 0);
    total++; if (redirect_pc !== 32'h1002) $display("FAIL t2_neg_pc got %h want 00001002", redirect_pc); else passed++;
    repeat (3) tick;
    issue(32'h1000, 32'hE3FF, 1, 1, 0);
    total++; if (redirect_pc !== 32'h1802) $display("FAIL t2_prio_pc got %h want 00001802", redirect_pc); else passed++;
    total++; if (st !== 4'b0110) $display("FAIL t2_prio_status got %b want 0110", st); else passed++;
    repeat (3) tick;
  endtask
  task automatic test_backpressure;
    redirect_ready = 0;
    issue(32'h300, 32'hD005, 0, 1, 1);
    ex_valid = 1; ex_is_b = 1; ex_pc = 32'h400; ex_instr = 32'hE010;
    for (int i = 0; i < 5; i++) begin
      total++; if (st !== 4'b0110) $display("FAIL bp_status[%0d] got %b want 0110", i, st); else passed++;
      total++; if (redirect_pc !== 32'h30E) $display("FAIL bp_pc[%0d] got %h want 0000030e", i, redirect_pc); else passed++;
      tick;
    end
    clear_ex;
    redirect_ready = 1;
    tick;
    total++; if (st !== 4'b0010) $display("FAIL bp_flush got %b want 0010", st); else passed++;
    tick; tick;
    total++; if (st !== 4'b1000) $display("FAIL bp_idle got %b want 1000", st); else passed++;
    total++; if (redirect_pc !== 32'h30E) $display("FAIL bp_second_ignored got %h want 0000030e", redirect_pc); else passed++;
  endtask
  task automatic test_reset_mid;
    redirect_ready = 0;
    issue(32'h100, 32'hD005, 0, 1, 1);
    total++; if (st !== 4'b0110) $display("FAIL rstmid_pre got %b want 0110", st); else passed++;
    rst = 1;
    tick;
    rst = 0;
    total++; if (st !== 4'b1000) $display("FAIL rstmid_status got %b want 1000", st); else passed++;
    total++; if (redirect_pc !== 32'h0) $display("FAIL rstmid_pc got %h want 00000000", redirect_pc); else passed++;
    redirect_ready = 1;
    tick;
    total++; if (st !== 4'b1000) $display("FAIL rstmid_dropped got %b want 1000", st); else passed++;
  endtask
  task automatic test_undef;
    issue(32'h700, 32'hDF00, 0, 1, 1);
    total++; if (st !== 4'b1001) $display("FAIL undef_pulse got %b want 1001", st); else passed++;
    tick;
    total++; if (st !== 4'b1000) $display("FAIL undef_clear got %b want 1000", st); else passed++;
    issue(32'h700, 32'hDE00, 0, 1, 0);
    total++; if (st !== 4'b1001) $display("FAIL undef_al got %b want 1001", st); else passed++;
    total++; if (redirect_pc !== 32'h0) $display("FAIL undef_pc got %h want 00000000", redirect_pc); else passed++;
    tick;
  endtask
  initial begin
    test_reset;
    test_beq_taken;
    test_backward;
    test_not_taken;
    test_t2;
    test_backpressure;
    test_reset_mid;
    test_undef;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
